pulse_sequencer: RTL and testbench
==================================

Name: pulse_sequencer

Overview:
- Synthesizable controller that shares one trigger/pulse-train output between N requesters.
- Round-robin arbitration picks a requester. The block waits a programmable delay, then emits a programmable burst of pulses on `signal`.
- Replaces free-running behavioural pulse/trigger generators with a clock-driven, cycle-exact sequencer. Sits between the clock source and any consumer of `signal`.

Parameters:
- N, 4, number of requesters (2..8).
- DW, 8, width of delay and pulse-width fields (cycles).
- CW, 4, width of pulse-count field.

Ports:
- clock, input, 1, single system clock; all logic on posedge.
- reset, input, 1, synchronous, active-high reset.
- req, input, N, request per requester; level, held until granted.
- delay, input, DW, cycles between grant and first high phase.
- high_w, input, DW, cycles each pulse stays high.
- low_w, input, DW, cycles between pulses.
- count, input, CW, pulses per burst.
- grant, output, N, one-hot; asserted for exactly one cycle on acceptance.
- owner, output, $clog2(N), index of current/last granted requester.
- busy, output, 1, high from the cycle after grant through the DONE cycle.
- signal, output, 1, shared pulse output (registered).
- done, output, 1, one-cycle strobe at end of burst.

Behaviour:
- Reset values:
  - grant=0, owner=0, busy=0, signal=0, done=0.
  - Round-robin pointer=0; state=IDLE; all counters=0.
  - Reset wins over every other event, including mid-burst: `signal` drops on the next edge and the burst is abandoned.
- IDLE:
  - If req!=0, grant the first set bit searching upward from pointer, with wrap-around.
  - Assert that grant bit for 1 cycle; owner=index; pointer=index+1 mod N.
  - Latch delay/high_w/low_w/count into internal registers; later input changes are ignored until the next grant.
  - Next state: DELAY.
- DELAY: wait latched delay cycles, then go to HIGH. delay=0 means HIGH in the cycle right after grant.
- HIGH: signal=1 for max(high_w,1) cycles. Decrement the remaining-pulse count on exit. Go to LOW if pulses remain, else DONE.
- LOW: signal=0 for max(low_w,1) cycles, then HIGH.
- DONE: signal=0, done=1, busy=1 for 1 cycle, then IDLE. A new grant is possible in the cycle after DONE.
- count=0 is treated as 1. Counters are DW/CW wide and never wrap: they load the value, count down, and exit at 1.
- Latency from req to signal rising, with req rising while IDLE: grant at edge k; signal=1 at edge k+1+delay.
- Total burst cycles = delay + count*high + (count-1)*low, plus 1 DONE cycle.
- Requests arriving while busy are not granted; they must stay asserted. A requester dropping req while not granted is simply skipped.
- Simultaneous requests: the round-robin pointer decides. Every asserted requester is served within N bursts.

Optional Feature:
- Macro: PULSE_SEQ_ABORT_EN.
- With the macro: input port `abort` (1 bit).
  - abort=1 in DELAY/HIGH/LOW forces signal=0 next edge and goes to DONE; done still strobes.
  - abort in IDLE or DONE is ignored.
- Without the macro: no `abort` port, and bursts always run to completion.

Decomposition:
- Package pulse_seq_pkg holds:
  - state enum (IDLE, DELAY, HIGH, LOW, DONE);
  - default widths DW/CW;
  - localparam for minimum phase length (1).
- One natural sub-module: rr_arbiter (N-bit req in; one-hot grant and index out; pointer update on accept). Instantiated once.
- The timing FSM and counters stay in pulse_sequencer.

Test Plan:
- Single burst: reset 2 cycles, req=4'b0001 with delay=3, high_w=2, low_w=1, count=3.
  - Expected: grant[0] for one cycle; signal pattern 0,0,0,1,1,0,1,1,0,1,1; done one cycle later; busy low afterwards.
- Round-robin: req=4'b1111 held with count=1, delay=0, high_w=1.
  - Expected: grants in order 0,1,2,3,0; each burst is 1 high cycle + DONE.
- Zero fields: delay=0, high_w=0, low_w=0, count=0.
  - Expected: exactly one pulse, 1 cycle wide, in the cycle after grant.
- Mid-burst reset: assert reset during the HIGH phase of a count=5 burst.
  - Expected: signal=0, busy=0, grant=0 at the next edge; fresh grant after reset drops and req is held.
- Config change during burst: change high_w from 2 to 7 after grant.
  - Expected: the current burst keeps width 2; the next grant uses 7.
- With PULSE_SEQ_ABORT_EN: abort during LOW of a count=4 burst.
  - Expected: signal stays 0; done strobes next cycle; the next requester is granted after DONE.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared state encoding and width defaults for the pulse sequencer
package pulse_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELAY,
      ST_HIGH,
      ST_LOW,
      ST_DONE
   } state_t;

   localparam int DEF_DW    = 8;
   localparam int DEF_CW    = 4;
   localparam int MIN_PHASE = 1;

endpackage

// File: rtl/pulse_sequencer_if.sv
// rtl/pulse_sequencer_if.sv - request/config/status bundle between requesters and the pulse sequencer
interface pulse_sequencer_if import pulse_seq_pkg::*; #(
   parameter int N  = 4,
   parameter int DW = DEF_DW,
   parameter int CW = DEF_CW
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  req;
   logic [DW-1:0] delay;
   logic [DW-1:0] high_w;
   logic [DW-1:0] low_w;
   logic [CW-1:0] count;
   logic [N-1:0]  grant;
   logic [IW-1:0] owner;
   logic          busy;
   logic          signal;
   logic          done;

   modport master (
      output req, delay, high_w, low_w, count,
      input  grant, owner, busy, signal, done
   );

   modport slave (
      input  req, delay, high_w, low_w, count,
      output grant, owner, busy, signal, done
   );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker; search starts at the pointer, pointer moves past each accepted winner
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          accept,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          valid
);

   logic [IW-1:0] ptr;
   int            j;

   always_comb begin
      grant = '0;
      index = '0;
      valid = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!valid && req[j]) begin
            valid    = 1'b1;
            index    = IW'(j);
            grant[j] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (accept && valid) begin
         ptr <= (index == IW'(N - 1)) ? '0 : index + IW'(1);
      end
   end

endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - arbitrated delay + pulse-burst generator on one shared output
// Optional abort input is compiled in with PULSE_SEQ_ABORT_EN.
module pulse_sequencer import pulse_seq_pkg::*; #(
   parameter int N  = 4,
   parameter int DW = DEF_DW,
   parameter int CW = DEF_CW
) (
   input  logic clock,
   input  logic reset,
`ifdef PULSE_SEQ_ABORT_EN
   input  logic abort,
`endif
   pulse_sequencer_if.slave bus
);
   localparam int IW = $clog2(N);

   state_t        state, nstate;
   logic [N-1:0]  grant_q;
   logic [IW-1:0] owner_q;
   logic          signal_q;
   logic [DW-1:0] phase_cnt;
   logic [CW-1:0] pulse_cnt;
   logic [DW-1:0] lat_high;
   logic [DW-1:0] lat_low;

   logic [N-1:0]  arb_grant;
   logic [IW-1:0] arb_index;
   logic          arb_valid;
   logic          accept;

   assign accept = (state == ST_IDLE) && arb_valid;

   rr_arbiter #(.N(N), .IW(IW)) u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    (bus.req),
      .accept (accept),
      .grant  (arb_grant),
      .index  (arb_index),
      .valid  (arb_valid)
   );

   always_comb begin
      nstate = state;
      case (state)
         ST_IDLE:  if (accept) nstate = ST_DELAY;
         ST_DELAY: if (phase_cnt == '0) nstate = ST_HIGH;
         ST_HIGH:  if (phase_cnt <= DW'(MIN_PHASE))
                      nstate = (pulse_cnt <= CW'(1)) ? ST_DONE : ST_LOW;
         ST_LOW:   if (phase_cnt <= DW'(MIN_PHASE)) nstate = ST_HIGH;
         ST_DONE:  nstate = ST_IDLE;
         default:  nstate = ST_IDLE;
      endcase
`ifdef PULSE_SEQ_ABORT_EN
      if (abort && (state == ST_DELAY || state == ST_HIGH || state == ST_LOW))
         nstate = ST_DONE;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         signal_q  <= 1'b0;
         phase_cnt <= '0;
         pulse_cnt <= '0;
         lat_high  <= '0;
         lat_low   <= '0;
      end else begin
         state    <= nstate;
         grant_q  <= accept ? arb_grant : '0;
         signal_q <= (nstate == ST_HIGH);
         // Delay counts down to zero; pulse phases load at least one cycle and exit at one.
         if (accept) begin
            owner_q   <= arb_index;
            phase_cnt <= bus.delay;
            lat_high  <= (bus.high_w == '0) ? DW'(MIN_PHASE) : bus.high_w;
            lat_low   <= (bus.low_w == '0) ? DW'(MIN_PHASE) : bus.low_w;
            pulse_cnt <= (bus.count == '0) ? CW'(1) : bus.count;
         end else if (nstate == ST_HIGH && state != ST_HIGH) begin
            phase_cnt <= lat_high;
         end else if (nstate == ST_LOW && state != ST_LOW) begin
            phase_cnt <= lat_low;
         end else if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - DW'(1);
         end
         if (state == ST_HIGH && nstate != ST_HIGH && pulse_cnt > CW'(1))
            pulse_cnt <= pulse_cnt - CW'(1);
      end
   end

   assign bus.grant  = grant_q;
   assign bus.owner  = owner_q;
   assign bus.busy   = (state != ST_IDLE);
   assign bus.signal = signal_q;
   assign bus.done   = (state == ST_DONE);

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - self-checking bench: burst-timeline reference model plus directed literal checks
module tb_pulse_sequencer;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
`ifdef PULSE_SEQ_ABORT_EN
   logic abort = 1'b0;
`endif

   always #5 clock = ~clock;

   pulse_sequencer_if #(.N(N), .DW(DW), .CW(CW)) bus ();

   pulse_sequencer #(.N(N), .DW(DW), .CW(CW)) dut (
      .clock (clock),
      .reset (reset),
`ifdef PULSE_SEQ_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: on grant, the whole burst is expanded into a per-cycle list of
   // {signal, done} entries; the list is empty exactly when the sequencer is idle.
   typedef struct {
      bit sig;
      bit dn;
   } ent_t;

   ent_t     q[$];
   int       m_ptr   = 0;
   int       m_owner = 0;
   bit [N-1:0] m_gnt = '0;
   bit       chk_en  = 1'b0;

   always @(posedge clock) begin
      int d, h, l, c, idx;
      if (reset) begin
         q.delete();
         m_ptr   = 0;
         m_owner = 0;
         m_gnt   = '0;
         chk_en  = 1'b1;
      end else begin
         m_gnt = '0;
         if (q.size() != 0) begin
`ifdef PULSE_SEQ_ABORT_EN
            if (abort && !q[0].dn) begin
               q.delete();
               q.push_back('{sig: 1'b0, dn: 1'b1});
            end else
               void'(q.pop_front());
`else
            void'(q.pop_front());
`endif
         end else if (bus.req != '0) begin
            idx = -1;
            for (int i = 0; i < N; i++)
               if (idx < 0 && bus.req[(m_ptr + i) % N]) idx = (m_ptr + i) % N;
            m_gnt[idx] = 1'b1;
            m_owner    = idx;
            m_ptr      = (idx + 1) % N;
            d = int'(bus.delay);
            h = (bus.high_w == 0) ? 1 : int'(bus.high_w);
            l = (bus.low_w == 0) ? 1 : int'(bus.low_w);
            c = (bus.count == 0) ? 1 : int'(bus.count);
            repeat (d + 1) q.push_back('{sig: 1'b0, dn: 1'b0});
            for (int p = 0; p < c; p++) begin
               repeat (h) q.push_back('{sig: 1'b1, dn: 1'b0});
               if (p < c - 1) repeat (l) q.push_back('{sig: 1'b0, dn: 1'b0});
            end
            q.push_back('{sig: 1'b0, dn: 1'b1});
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("grant",  32'(bus.grant),  32'(m_gnt));
         check("owner",  32'(bus.owner),  32'(m_owner));
         check("busy",   32'(bus.busy),   32'(q.size() != 0));
         check("signal", 32'(bus.signal), 32'((q.size() != 0) ? q[0].sig : 1'b0));
         check("done",   32'(bus.done),   32'((q.size() != 0) ? q[0].dn : 1'b0));
      end
   end

   task automatic do_reset(input int cycles);
      @(negedge clock);
      reset   = 1'b1;
      bus.req = '0;
      repeat (cycles) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic set_cfg(input int d, input int h, input int l, input int c);
      bus.delay  = DW'(d);
      bus.high_w = DW'(h);
      bus.low_w  = DW'(l);
      bus.count  = CW'(c);
   endtask

   task automatic wait_grant(output int cycles);
      bit ok;
      ok = 1'b0;
      cycles = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         cycles++;
         if (bus.grant != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("grant_timeout", 32'(ok), 32'd1);
   endtask

   task automatic measure_width(output int w);
      w = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clock);
         if (bus.signal) w++;
         if (bus.done) break;
      end
   endtask

   initial begin
      logic [12:0] sig_v, done_v;
      logic [2:0]  zs_v, zd_v;
      int cyc, w;

      bus.req = '0;
      set_cfg(0, 1, 1, 1);

      // Single burst: delay 3, high 2, low 1, three pulses.
      do_reset(2);
      check("reset_busy",   32'(bus.busy),   32'd0);
      check("reset_signal", 32'(bus.signal), 32'd0);
      set_cfg(3, 2, 1, 3);
      bus.req = 4'b0001;
      wait_grant(cyc);
      check("single_grant", 32'(bus.grant), 32'h1);
      bus.req = '0;
      sig_v  = '0;
      done_v = '0;
      for (int i = 0; i < 13; i++) begin
         if (i > 0) @(negedge clock);
         sig_v  = {sig_v[11:0], bus.signal};
         done_v = {done_v[11:0], bus.done};
      end
      check("single_signal", 32'(sig_v),  32'(13'b0000110110110));
      check("single_done",   32'(done_v), 32'(13'b0000000000001));
      @(negedge clock);
      check("single_idle_busy", 32'(bus.busy), 32'd0);

      // Round-robin with every requester held.
      do_reset(2);
      set_cfg(0, 1, 0, 1);
      bus.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_grant(cyc);
         check("rr_grant", 32'(bus.grant), 32'(1 << (g % 4)));
         if (g > 0) check("rr_interval", 32'(cyc), 32'd4);
      end
      bus.req = '0;

      // All-zero fields: one single-cycle pulse right after grant.
      do_reset(2);
      set_cfg(0, 0, 0, 0);
      bus.req = 4'b0001;
      wait_grant(cyc);
      bus.req = '0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clock);
         zs_v[2-i] = bus.signal;
         zd_v[2-i] = bus.done;
      end
      check("zero_signal", 32'(zs_v), 32'(3'b010));
      check("zero_done",   32'(zd_v), 32'(3'b001));
      @(negedge clock);
      check("zero_idle_busy", 32'(bus.busy), 32'd0);

      // Reset while the output is high, requester keeps asking.
      do_reset(2);
      set_cfg(0, 3, 1, 5);
      bus.req = 4'b0010;
      wait_grant(cyc);
      for (int i = 0; i < 20 && !bus.signal; i++) @(negedge clock);
      check("mid_high_reached", 32'(bus.signal), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      check("mid_reset_signal", 32'(bus.signal), 32'd0);
      check("mid_reset_busy",   32'(bus.busy),   32'd0);
      check("mid_reset_grant",  32'(bus.grant),  32'd0);
      reset = 1'b0;
      wait_grant(cyc);
      check("mid_regrant", 32'(bus.grant), 32'h2);
      check("mid_regrant_cyc", 32'(cyc), 32'd1);
      bus.req = '0;

      // Config change after grant only affects the following burst.
      do_reset(2);
      set_cfg(0, 2, 0, 1);
      bus.req = 4'b0001;
      wait_grant(cyc);
      bus.req    = '0;
      bus.high_w = DW'(7);
      measure_width(w);
      check("cfg_width_old", 32'(w), 32'd2);
      bus.req = 4'b0100;
      wait_grant(cyc);
      bus.req = '0;
      measure_width(w);
      check("cfg_width_new", 32'(w), 32'd7);

      // Randomized traffic against the model.
      do_reset(2);
      for (int t = 0; t < 4000; t++) begin
         @(negedge clock);
         for (int b = 0; b < N; b++) begin
            if (m_gnt[b])
               bus.req[b] = 1'b0;
            else if (!bus.req[b] && ($urandom % 8 == 0))
               bus.req[b] = 1'b1;
            else if (bus.req[b] && ($urandom % 64 == 0))
               bus.req[b] = 1'b0;
         end
         if ($urandom % 10 == 0)
            set_cfg($urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 4));
`ifdef PULSE_SEQ_ABORT_EN
         abort = ($urandom % 40 == 0);
`endif
         reset = ($urandom % 600 == 0);
      end
      reset = 1'b0;
`ifdef PULSE_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
